conv_window_fetch: RTL
======================

// Module: conv_window_fetch
// PURPOSE
//  Parametrised 3x3 window fetcher for the CONV front end. Walks an IMG_W x IMG_H
//  grayscale image in raster order, reads taps via iaddr/idata, zero-pads border
//  taps (PAD_EN=1) or skips border centres (PAD_EN=0), supports stride 1/2, and
//  presents each complete 9-tap window on a valid/ready port to the MAC stage.
// PARAMETERS
//  IMG_W   64  image width in pixels (>=3)
//  IMG_H   64  image height in pixels (>=3)
//  DW      20  pixel width (bits)
//  AW      12  image address width; IMG_W*IMG_H <= 2**AW
//  PAD_EN  1   1: zero-padded "same" windows; 0: "valid" windows only
//  STRIDE  1   centre step in x and y; legal values 1, 2
// PORTS
//  clk        in   1      clock, all state on rising edge
//  reset      in   1      asynchronous, active-low reset
//  ready      in   1      image memory loaded; sampled only in IDLE
//  busy       out  1      frame in progress; image reads permitted
//  iaddr      out  AW     image read address (registered)
//  idata      in   DW     pixel at iaddr, valid one cycle after iaddr driven
//  win_valid  out  1      window on win_data is complete
//  win_ready  in   1      downstream accepts window
//  win_data   out  9*DW   tap k at [DW*k +: DW]; k=0 top-left, row-major, k=4 centre
//  win_x      out  7      centre column of presented window
//  win_y      out  7      centre row of presented window
//  done       out  1      one-cycle pulse after last window accepted
// BEHAVIOUR
//  Reset (reset=0, any time, incl. mid-frame): FSM->IDLE; busy, iaddr, win_valid,
//   win_data, win_x, win_y, done all 0; tap/centre counters cleared. Next frame
//   restarts at first centre. No partial window survives reset.
//  States: IDLE -> FETCH -> DRAIN -> PRESENT -> (FETCH | FIN) ; FIN -> IDLE.
//  IDLE: busy=0. If ready=1 at edge -> FETCH, busy=1, centre=first, k=0.
//  FETCH: one tap slot per cycle, k=0..8. Tap coord (cx+dx, cy+dy), dx,dy in {-1,0,1}.
//   In-range tap: iaddr <= ty*IMG_W + tx (truncated to AW). Out-of-range tap
//   (PAD_EN=1 only): iaddr holds, slot k marked zero. Capture is pipelined:
//   slot k-1 loads idata (or 0 if marked) while slot k issues. k=8 -> DRAIN.
//  DRAIN: slot 8 captured; -> PRESENT, win_valid=1. Window latency: 10 cycles
//   from FETCH entry to win_valid.
//  PRESENT: win_data/win_x/win_y stable while win_valid && !win_ready.
//   win_valid && win_ready at an edge = accept; if win_ready already high the
//   cycle win_valid rises, accept occurs that edge (no bubble). On accept,
//   win_valid<=0; if more centres -> FETCH k=0 next cycle, else -> FIN.
//  Centre order: x from XS step STRIDE while x <= XE, then y step STRIDE, x=XS.
//   PAD_EN=1: XS=YS=0, XE=IMG_W-1, YE=IMG_H-1. PAD_EN=0: XS=YS=1,
//   XE=IMG_W-2, YE=IMG_H-2. Last centre = last reachable (x,y) within bounds.
//  FIN: done=1 for one cycle, busy<=0 same edge, -> IDLE. ready high again
//   in IDLE starts a new frame (ready ignored while busy).
//  Window count: ceil((XE-XS+1)/STRIDE)*ceil((YE-YS+1)/STRIDE); 64x64 pad s1 = 4096.
//  Corners zero 5 taps, edges zero 3 taps, interior zero none.
//  Address arithmetic in signed AW+2 bits before range check; no wrap across rows.
// TESTING
//  T1 reset mid-FETCH (window 3, k=5) -> all outputs 0 within same cycle, IDLE; next
//     ready -> first window centre (0,0) repeats.
//  T2 64x64 ramp idata=addr, PAD_EN=1: window (0,0) taps = {0,0,0,0,0,1,0,64,65};
//     window (63,63) taps = {4030,4031,0,4094,4095,0,0,0,0}; 4096 windows, done once.
//  T3 PAD_EN=0 STRIDE=1 same image: first centre (1,1) taps {0,1,2,64,65,66,128,129,130};
//     3844 windows; iaddr never out of range.
//  T4 STRIDE=2 PAD_EN=1: centres (0,0),(2,0)..(62,62); 1024 windows.
//  T5 win_ready held 0 for 7 cycles at window 10 -> win_data stable, no new iaddr;
//     win_ready tied 1 -> windows every 11 cycles exactly.
//  T6 ready pulsed during busy -> ignored; after done, ready=1 -> second frame identical.

Source files
------------

// File: rtl/conv_window_fetch.sv
// 3x3 window fetcher: walks the image centres in raster order, reads each tap
// through a registered address port, zero-fills taps that fall outside the image
// (padded mode) and hands complete windows to the MAC stage over valid/ready.
module conv_window_fetch #(
   parameter int IMG_W  = 64,
   parameter int IMG_H  = 64,
   parameter int DW     = 20,
   parameter int AW     = 12,
   parameter int PAD_EN = 1,
   parameter int STRIDE = 1
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            ready,
   output logic            busy,
   output logic [AW-1:0]   iaddr,
   input  logic [DW-1:0]   idata,
   output logic            win_valid,
   input  logic            win_ready,
   output logic [9*DW-1:0] win_data,
   output logic [6:0]      win_x,
   output logic [6:0]      win_y,
   output logic            done
);

   // Coordinates are kept signed and two bits wider than the address so that
   // border taps at -1 and at IMG_W / IMG_H can be range-checked without wrap.
   localparam int SW = AW + 2;
   localparam int XS = (PAD_EN != 0) ? 0 : 1;
   localparam int YS = (PAD_EN != 0) ? 0 : 1;
   localparam int XE = (PAD_EN != 0) ? IMG_W - 1 : IMG_W - 2;
   localparam int YE = (PAD_EN != 0) ? IMG_H - 1 : IMG_H - 2;

   localparam logic signed [SW-1:0] W_S    = SW'(IMG_W);
   localparam logic signed [SW-1:0] H_S    = SW'(IMG_H);
   localparam logic signed [SW-1:0] XS_S   = SW'(XS);
   localparam logic signed [SW-1:0] YS_S   = SW'(YS);
   localparam logic signed [SW-1:0] XE_S   = SW'(XE);
   localparam logic signed [SW-1:0] YE_S   = SW'(YE);
   localparam logic signed [SW-1:0] STEP_S = SW'(STRIDE);
   localparam logic signed [SW-1:0] ONE_S  = SW'(1);
   localparam logic signed [SW-1:0] ZERO_S = '0;
   localparam logic signed [SW-1:0] NEG_S  = '1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_DRAIN,
      S_PRESENT,
      S_FIN
   } state_t;

   state_t                 state;
   logic signed [SW-1:0]   cx;
   logic signed [SW-1:0]   cy;
   logic [3:0]             k;
   logic                   pend_zero;

   logic signed [SW-1:0]   dx;
   logic signed [SW-1:0]   dy;
   logic signed [SW-1:0]   tx;
   logic signed [SW-1:0]   ty;
   logic signed [SW-1:0]   nx;
   logic signed [SW-1:0]   ny;
   logic                   tap_in;
   logic [AW-1:0]          tap_addr;
   logic [3:0]             cap_slot;
   logic [DW-1:0]          cap_val;

   // Tap offset, tap address and range check for the slot being issued, plus
   // the next-centre candidates and the value captured for the previous slot.
   always_comb begin
      dx = ZERO_S;
      dy = ZERO_S;
      case (k)
         4'd0, 4'd3, 4'd6: dx = NEG_S;
         4'd2, 4'd5, 4'd8: dx = ONE_S;
         default:          dx = ZERO_S;
      endcase
      if (k < 4'd3) begin
         dy = NEG_S;
      end else if (k > 4'd5) begin
         dy = ONE_S;
      end
      tx       = cx + dx;
      ty       = cy + dy;
      tap_in   = (tx >= ZERO_S) && (tx < W_S) && (ty >= ZERO_S) && (ty < H_S);
      tap_addr = AW'(ty * W_S + tx);
      nx       = cx + STEP_S;
      ny       = cy + STEP_S;
      cap_slot = (state == S_FETCH) ? k - 4'd1 : 4'd8;
      cap_val  = pend_zero ? '0 : idata;
   end

   // Frame sequencer: issues one tap per FETCH cycle and captures the previous
   // slot in the same cycle, so the read data lags its address by one cycle.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= S_IDLE;
         busy      <= 1'b0;
         iaddr     <= '0;
         win_valid <= 1'b0;
         win_data  <= '0;
         win_x     <= '0;
         win_y     <= '0;
         done      <= 1'b0;
         cx        <= '0;
         cy        <= '0;
         k         <= '0;
         pend_zero <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (ready) begin
                  state <= S_FETCH;
                  busy  <= 1'b1;
                  cx    <= XS_S;
                  cy    <= YS_S;
                  k     <= '0;
               end
            end
            S_FETCH: begin
               // Padded taps leave iaddr untouched; the pending-zero flag makes
               // the capture of that slot load zero instead of idata.
               if (tap_in) begin
                  iaddr <= tap_addr;
               end
               pend_zero <= !tap_in;
               if (k != 4'd0) begin
                  win_data[DW*int'(cap_slot) +: DW] <= cap_val;
               end
               if (k == 4'd8) begin
                  k     <= '0;
                  state <= S_DRAIN;
               end else begin
                  k <= k + 4'd1;
               end
            end
            S_DRAIN: begin
               win_data[DW*int'(cap_slot) +: DW] <= cap_val;
               win_valid <= 1'b1;
               win_x     <= 7'(cx);
               win_y     <= 7'(cy);
               state     <= S_PRESENT;
            end
            S_PRESENT: begin
               if (win_ready) begin
                  win_valid <= 1'b0;
                  if (nx <= XE_S) begin
                     cx    <= nx;
                     state <= S_FETCH;
                  end else if (ny <= YE_S) begin
                     cx    <= XS_S;
                     cy    <= ny;
                     state <= S_FETCH;
                  end else begin
                     state <= S_FIN;
                     done  <= 1'b1;
                     busy  <= 1'b0;
                  end
               end
            end
            S_FIN: begin
               state <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule
